// File: rtl/posit_mul_core_if.sv
// rtl/posit_mul_core_if.sv - operand/result handshake bundle for posit_mul_core
interface posit_mul_core_if #(
  parameter int RS = 5,
  parameter int ES = 1,
  parameter int FS = 12
);
  logic          in_valid;
  logic          in_ready;
  logic          a_sign;
  logic          b_sign;
  logic [RS-1:0] a_regi;
  logic [RS-1:0] b_regi;
  logic [ES-1:0] a_expo;
  logic [ES-1:0] b_expo;
  logic [FS-1:0] a_frac;
  logic [FS-1:0] b_frac;
  logic          a_allzero;
  logic          b_allzero;
  logic          a_allone;
  logic          b_allone;

  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [7:0]    out_scale;
  logic [23:0]   out_frac;
  logic          out_sticky;
  logic          out_zero;
  logic          out_nar;

  modport slave (
    input  in_valid, a_sign, b_sign, a_regi, b_regi, a_expo, b_expo,
           a_frac, b_frac, a_allzero, b_allzero, a_allone, b_allone, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_frac, out_sticky,
           out_zero, out_nar
  );

  modport master (
    output in_valid, a_sign, b_sign, a_regi, b_regi, a_expo, b_expo,
           a_frac, b_frac, a_allzero, b_allzero, a_allone, b_allone, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_frac, out_sticky,
           out_zero, out_nar
  );
endinterface

// File: rtl/posit_mul_core.sv
// rtl/posit_mul_core.sv - 3-stage posit(16,1) field multiplier producing an
// unrounded normalised product for the downstream rounder/encoder.
module posit_mul_core #(
  parameter int RS = 5,
  parameter int ES = 1,
  parameter int FS = 12
) (
  input logic            clk,
  input logic            rst,
  posit_mul_core_if.slave bus
);
  localparam int MW = FS + 1;
  localparam int PW = 2 * MW;
  localparam int SW = 8;

  logic ready1, ready2, ready3;
  logic v1_q, v2_q, v3_q;

  logic          s1_sign_q, s1_nar_q, s1_zero_q;
  logic [SW-1:0] s1_scale_q;
  logic [MW-1:0] s1_ma_q, s1_mb_q;

  logic          s2_sign_q, s2_nar_q, s2_zero_q;
  logic [SW-1:0] s2_scale_q;
  logic [PW-1:0] s2_prod_q;

  logic          out_sign_q, out_sticky_q, out_zero_q, out_nar_q;
  logic [SW-1:0] out_scale_q;
  logic [23:0]   out_frac_q;

  logic          a_nar, b_nar, a_zero, b_zero;
  logic          s1_nar_d, s1_zero_d;
  logic [SW-1:0] a_scale, b_scale, s1_scale_d;

  logic          out_sign_d, out_sticky_d;
  logic [SW-1:0] out_scale_d;
  logic [23:0]   out_frac_d;

  logic          unused_allone;
  assign unused_allone = bus.a_allone | bus.b_allone;

  assign ready3       = ~v3_q | bus.out_ready;
  assign ready2       = ~v2_q | ready3;
  assign ready1       = ~v1_q | ready2;
  assign bus.in_ready = ready1;

  assign a_nar  = bus.a_allzero & bus.a_sign;
  assign b_nar  = bus.b_allzero & bus.b_sign;
  assign a_zero = bus.a_allzero & ~bus.a_sign;
  assign b_zero = bus.b_allzero & ~bus.b_sign;

  // 2k+e with ES=1 is just {k, e}: the regime shift leaves the LSB free for e.
  assign a_scale    = {{(SW-RS-ES){bus.a_regi[RS-1]}}, bus.a_regi, bus.a_expo};
  assign b_scale    = {{(SW-RS-ES){bus.b_regi[RS-1]}}, bus.b_regi, bus.b_expo};
  assign s1_scale_d = a_scale + b_scale;
  assign s1_nar_d   = a_nar | b_nar;
  assign s1_zero_d  = ~s1_nar_d & (a_zero | b_zero);

  always_comb begin
    out_sign_d   = s2_sign_q;
    out_scale_d  = s2_scale_q;
    out_frac_d   = s2_prod_q[23:0];
    out_sticky_d = 1'b0;
    if (s2_prod_q[PW-1]) begin
      out_scale_d  = s2_scale_q + 8'd1;
      out_frac_d   = s2_prod_q[PW-2:1];
      out_sticky_d = s2_prod_q[0];
    end
    if (s2_nar_q | s2_zero_q) begin
      out_sign_d   = 1'b0;
      out_scale_d  = '0;
      out_frac_d   = '0;
      out_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_scale_q <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else if (ready1) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q  <= bus.a_sign ^ bus.b_sign;
        s1_nar_q   <= s1_nar_d;
        s1_zero_q  <= s1_zero_d;
        s1_scale_q <= s1_scale_d;
        s1_ma_q    <= {1'b1, bus.a_frac};
        s1_mb_q    <= {1'b1, bus.b_frac};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q       <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_scale_q <= '0;
      s2_prod_q  <= '0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_sign_q  <= s1_sign_q;
        s2_nar_q   <= s1_nar_q;
        s2_zero_q  <= s1_zero_q;
        s2_scale_q <= s1_scale_q;
        s2_prod_q  <= s1_ma_q * s1_mb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q         <= 1'b0;
      out_sign_q   <= 1'b0;
      out_scale_q  <= '0;
      out_frac_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_nar_q    <= 1'b0;
    end else if (ready3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_sign_q   <= out_sign_d;
        out_scale_q  <= out_scale_d;
        out_frac_q   <= out_frac_d;
        out_sticky_q <= out_sticky_d;
        out_zero_q   <= s2_zero_q;
        out_nar_q    <= s2_nar_q;
      end
    end
  end

  assign bus.out_valid  = v3_q;
  assign bus.out_sign   = out_sign_q;
  assign bus.out_scale  = out_scale_q;
  assign bus.out_frac   = out_frac_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_nar    = out_nar_q;
endmodule

// File: tb/tb_posit_mul_core.sv
// tb/tb_posit_mul_core.sv - directed self-checking bench for posit_mul_core
module tb_posit_mul_core;
  localparam int NV = 10;

  typedef struct {
    logic        as, bs;
    logic [4:0]  ak, bk;
    logic        ae, be;
    logic [11:0] af, bf;
    logic        az, bz;
    logic [35:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vt[NV];

  posit_mul_core_if bus ();

  posit_mul_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ex(input logic nar, input logic zero, input logic sign,
                                     input logic [7:0] scale, input logic [23:0] frac,
                                     input logic sticky);
    return {nar, zero, sign, scale, frac, sticky};
  endfunction

  function automatic vec_t mk(input logic as, input logic [4:0] ak, input logic ae,
                              input logic [11:0] af, input logic az,
                              input logic bs, input logic [4:0] bk, input logic be,
                              input logic [11:0] bf, input logic bz,
                              input logic [35:0] exp);
    vec_t v;
    v.as = as; v.ak = ak; v.ae = ae; v.af = af; v.az = az;
    v.bs = bs; v.bk = bk; v.be = be; v.bf = bf; v.bz = bz;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [35:0] pack_out();
    return {bus.out_nar, bus.out_zero, bus.out_sign, bus.out_scale, bus.out_frac, bus.out_sticky};
  endfunction

  task automatic drive_vec(input int i, input logic valid);
    bus.in_valid  = valid;
    bus.a_sign    = vt[i].as;  bus.b_sign    = vt[i].bs;
    bus.a_regi    = vt[i].ak;  bus.b_regi    = vt[i].bk;
    bus.a_expo    = vt[i].ae;  bus.b_expo    = vt[i].be;
    bus.a_frac    = vt[i].af;  bus.b_frac    = vt[i].bf;
    bus.a_allzero = vt[i].az;  bus.b_allzero = vt[i].bz;
    bus.a_allone  = (vt[i].ak == 5'd14) && !vt[i].ae && (vt[i].af == 12'h0) && !vt[i].az;
    bus.b_allone  = (vt[i].bk == 5'd14) && !vt[i].be && (vt[i].bf == 12'h0) && !vt[i].bz;
  endtask

  initial begin
    int idx, got, cyc, acc_stall, stale, waited;
    logic fire_in, found;
    n_checks = 0;
    n_fail   = 0;

    vt[0] = mk(0, 5'd0,  0, 12'h000, 0,  0, 5'd0,  0, 12'h000, 0, ex(0, 0, 0, 8'd0,  24'h000000, 0));
    vt[1] = mk(0, 5'd0,  0, 12'h800, 0,  0, 5'd0,  0, 12'h800, 0, ex(0, 0, 0, 8'd1,  24'h200000, 0));
    vt[2] = mk(1, 5'd0,  1, 12'h000, 0,  0, 5'd0,  1, 12'h800, 0, ex(0, 0, 1, 8'd2,  24'h800000, 0));
    vt[3] = mk(0, 5'd14, 0, 12'h000, 0,  0, 5'd14, 0, 12'h000, 0, ex(0, 0, 0, 8'd56, 24'h000000, 0));
    vt[4] = mk(0, 5'h11, 0, 12'h000, 0,  0, 5'h11, 0, 12'h000, 0, ex(0, 0, 0, 8'hC4, 24'h000000, 0));
    vt[5] = mk(1, 5'd3,  1, 12'h123, 1,  0, 5'd1,  0, 12'h000, 1, ex(1, 0, 0, 8'd0,  24'h000000, 0));
    vt[6] = mk(0, 5'd0,  0, 12'h000, 1,  1, 5'd0,  0, 12'h800, 0, ex(0, 1, 0, 8'd0,  24'h000000, 0));
    vt[7] = mk(1, 5'd0,  0, 12'h000, 1,  0, 5'd0,  0, 12'h000, 0, ex(1, 0, 0, 8'd0,  24'h000000, 0));
    vt[8] = mk(1, 5'd0,  0, 12'hFFF, 0,  1, 5'd0,  0, 12'hFFF, 0, ex(0, 0, 0, 8'd1,  24'hFFE000, 1));
    vt[9] = mk(0, 5'h1D, 1, 12'h001, 0,  1, 5'd2,  0, 12'h000, 0, ex(0, 0, 1, 8'hFF, 24'h001000, 0));

    // reset state
    rst = 1'b1;
    drive_vec(0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_outputs", 64'(pack_out()), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single-op latency: 1.0 x 1.0
    drive_vec(0, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("lat_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("lat_valid_%0d", k), 64'(bus.out_valid), 64'(k == 3));
      if (k == 3) check_eq("lat_result", 64'(pack_out()), 64'(vt[0].exp));
      @(posedge clk);
      #1;
    end

    // streamed vectors with initial backpressure
    idx = 0; got = 0; cyc = 0; acc_stall = 0;
    while (got < NV && cyc < 200) begin
      bus.out_ready = (cyc >= 5);
      if (idx < NV) drive_vec(idx, 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      fire_in = bus.in_valid & bus.in_ready;
      if (fire_in && cyc < 5) acc_stall++;
      if (cyc == 4) begin
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("full_hold", 64'(pack_out()), 64'(vt[0].exp));
      end
      if (cyc == 5) check_eq("release_in_ready", 64'(bus.in_ready), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        check_eq($sformatf("stream_%0d", got), 64'(pack_out()), 64'(vt[got].exp));
        got++;
      end
      @(posedge clk);
      #1;
      if (fire_in) idx++;
      cyc++;
    end
    check_eq("stall_accepts", 64'(acc_stall), 64'd3);
    check_eq("stream_count", 64'(got), 64'(NV));

    // reset mid-stream
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_vec(k + 1, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("async_rst_ready", 64'(bus.in_ready), 64'd1);
    check_eq("async_rst_outs", 64'(pack_out()), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_eq("no_stale", 64'(stale), 64'd0);

    // fresh operation after reset
    @(posedge clk);
    #1;
    drive_vec(8, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 10) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1;
        check_eq("post_rst_result", 64'(pack_out()), 64'(vt[8].exp));
      end
      waited++;
    end
    check_eq("post_rst_found", 64'(found), 64'd1);
    check_eq("post_rst_latency", 64'(waited), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
